// File: rtl/a2d_spi_pkg.sv
// Shared definitions for the A2D SPI responder.
// Holds the frame geometry, the channel field position inside the
// received command word, the responder state enum and the channel type.
package a2d_spi_pkg;

  localparam int unsigned FRAME_LEN = 16;
  localparam int unsigned CH_MSB    = 13;
  localparam int unsigned CH_LSB    = 11;

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    SHIFT
  } state_t;

  typedef logic [2:0] chnl_t;

endpackage

// File: rtl/a2d_spi_sync_edge.sv
// Multi-flop synchronizer with edge detection for one asynchronous input.
// Ports:
//   clk, rst_n : system clock, synchronous active-low reset
//   d          : asynchronous input
//   q          : synchronized level (last synchronizer stage)
//   rise, fall : one-cycle pulses on synchronized 0->1 / 1->0 transitions
// Parameters:
//   STAGES  : synchronizer depth (2 or more)
//   RST_VAL : value loaded into every flop at reset (idle level of d)
module a2d_spi_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= {STAGES{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      prev <= sync[STAGES-1];
    end
  end

  assign q    = sync[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/a2d_spi_resp.sv
// SPI responder emulating an ADC128S-style converter for the A2D master.
// 16-bit frames: channel select arrives on MOSI bits [13:11], the 12-bit
// sample (zero-padded to 16 bits) leaves on MISO, both MSB first. Each
// frame returns the channel commanded by the previous complete frame.
// Ports:
//   clk, rst_n  : system clock, synchronous active-low reset
//   SS_n, SCLK, MOSI : master pins (asynchronous, synchronized here)
//   MISO        : result bit, 0 whenever no frame is being shifted
//   chnl_data   : NCH samples of DW bits, channel k at [k*DW +: DW]
//   cmd_vld     : one-cycle pulse when a complete frame ends
//   cmd_chnnl   : channel decoded from the last complete frame
//   frm_err     : (A2D_SPI_RESP_FRAME_ERR_EN only) one-cycle pulse when a
//                 frame ends with other than exactly 16 SCLK rises
// Build option: define A2D_SPI_RESP_FRAME_ERR_EN to add frm_err and to
// reject frames with more than 16 rises.
module a2d_spi_resp
  import a2d_spi_pkg::*;
#(
  parameter int unsigned DW          = 12,
  parameter int unsigned NCH         = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              SCLK,
  input  logic              MOSI,
  output logic              MISO,
  input  logic [NCH*DW-1:0] chnl_data,
  output logic              cmd_vld,
  output logic [2:0]        cmd_chnnl
`ifdef A2D_SPI_RESP_FRAME_ERR_EN
  ,
  output logic              frm_err
`endif
);

  localparam int unsigned CNT_W    = $clog2(FRAME_LEN + 1);
  localparam int unsigned SETTLE_W = $clog2(SYNC_STAGES + 1);

  state_t                 state, state_nxt;
  logic [FRAME_LEN-1:0]   tx_shift, tx_nxt;
  logic [FRAME_LEN-1:0]   rx_shift, rx_nxt;
  logic [CNT_W-1:0]       bit_cnt, cnt_nxt;
  logic [SETTLE_W-1:0]    settle, settle_nxt;
  chnl_t                  prev_ch, prev_nxt, chnnl_nxt;
  logic                   vld_nxt;
  logic [DW-1:0]          sample;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   mosi_q;
  logic                   ss_q, ss_rise, ss_fall;
  logic                   sclk_rise, sclk_fall;
  logic                   sclk_q_unused;
  logic                   rx_msb_unused;
`ifdef A2D_SPI_RESP_FRAME_ERR_EN
  logic                   over, over_nxt;
  logic                   err_nxt;
`endif

  a2d_spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (SS_n),
    .q    (ss_q),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  a2d_spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (SCLK),
    .q    (sclk_q_unused),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  // MOSI has the same depth as SCLK so a sampled bit lines up with its rise.
  always_ff @(posedge clk) begin
    if (!rst_n) mosi_sync <= '0;
    else        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
  end
  assign mosi_q = mosi_sync[SYNC_STAGES-1];

  assign sample        = chnl_data[DW*prev_ch +: DW];
  assign rx_msb_unused = rx_shift[FRAME_LEN-1];
  assign MISO          = (state == SHIFT) ? tx_shift[FRAME_LEN-1] : 1'b0;

  always_comb begin
    state_nxt  = state;
    tx_nxt     = tx_shift;
    rx_nxt     = rx_shift;
    cnt_nxt    = bit_cnt;
    settle_nxt = '0;
    prev_nxt   = prev_ch;
    chnnl_nxt  = cmd_chnnl;
    vld_nxt    = 1'b0;
`ifdef A2D_SPI_RESP_FRAME_ERR_EN
    over_nxt   = over;
    err_nxt    = 1'b0;
`endif
    case (state)
      // Synchronizer flops come out of reset at 1, so SS_n must be seen
      // high for longer than the synchronizer flush before a low SS_n left
      // over from an interrupted frame can no longer fake a fresh fall.
      WAIT_IDLE: begin
        if (ss_q) begin
          if (settle == SETTLE_W'(SYNC_STAGES)) state_nxt = IDLE;
          else                                   settle_nxt = settle + 1'b1;
        end
      end
      IDLE: begin
        if (ss_fall) begin
          tx_nxt    = FRAME_LEN'(sample);
          rx_nxt    = '0;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
`ifdef A2D_SPI_RESP_FRAME_ERR_EN
          over_nxt  = 1'b0;
`endif
        end
      end
      SHIFT: begin
        // SS_n rise wins over any SCLK edge detected in the same cycle.
        if (ss_rise) begin
          state_nxt = IDLE;
`ifdef A2D_SPI_RESP_FRAME_ERR_EN
          if (bit_cnt == CNT_W'(FRAME_LEN) && !over) begin
`else
          if (bit_cnt == CNT_W'(FRAME_LEN)) begin
`endif
            prev_nxt  = rx_shift[CH_MSB:CH_LSB];
            chnnl_nxt = rx_shift[CH_MSB:CH_LSB];
            vld_nxt   = 1'b1;
          end
`ifdef A2D_SPI_RESP_FRAME_ERR_EN
          else begin
            err_nxt = 1'b1;
          end
`endif
        end else if (sclk_rise) begin
          rx_nxt = {rx_shift[FRAME_LEN-2:0], mosi_q};
          if (bit_cnt != CNT_W'(FRAME_LEN)) cnt_nxt = bit_cnt + 1'b1;
`ifdef A2D_SPI_RESP_FRAME_ERR_EN
          else over_nxt = 1'b1;
`endif
        end else if (sclk_fall) begin
          // Falls after the 16th bit clear the register outright, which is
          // what continued zero-filled shifting would converge to.
          if (bit_cnt == CNT_W'(FRAME_LEN)) tx_nxt = '0;
          else if (bit_cnt != '0)           tx_nxt = {tx_shift[FRAME_LEN-2:0], 1'b0};
        end
      end
      default: state_nxt = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= WAIT_IDLE;
      tx_shift  <= '0;
      rx_shift  <= '0;
      bit_cnt   <= '0;
      settle    <= '0;
      prev_ch   <= '0;
      cmd_chnnl <= '0;
      cmd_vld   <= 1'b0;
`ifdef A2D_SPI_RESP_FRAME_ERR_EN
      over      <= 1'b0;
      frm_err   <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      tx_shift  <= tx_nxt;
      rx_shift  <= rx_nxt;
      bit_cnt   <= cnt_nxt;
      settle    <= settle_nxt;
      prev_ch   <= prev_nxt;
      cmd_chnnl <= chnnl_nxt;
      cmd_vld   <= vld_nxt;
`ifdef A2D_SPI_RESP_FRAME_ERR_EN
      over      <= over_nxt;
      frm_err   <= err_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Self-checking bench for a2d_spi_resp: an SPI master model drives frames,
// a reference model predicts the MISO word and command results, and a
// monitor process compares them against DUT outputs.
`timescale 1ns/1ps
module tb_a2d_spi_resp;

  localparam int DW  = 12;
  localparam int NCH = 8;
  localparam int H   = 4;   // SCLK half period in clk cycles (clk/8 limit)
  localparam int GAP = 10;  // idle clk cycles between frames
`ifdef A2D_SPI_RESP_FRAME_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              SS_n  = 1'b1;
  logic              SCLK  = 1'b1;
  logic              MOSI  = 1'b0;
  logic              MISO;
  logic [NCH*DW-1:0] chnl_data = '0;
  logic              cmd_vld;
  logic [2:0]        cmd_chnnl;
`ifdef A2D_SPI_RESP_FRAME_ERR_EN
  logic              frm_err;
`endif

  always #5 clk = ~clk;

  a2d_spi_resp #(.DW(DW), .NCH(NCH), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .chnl_data(chnl_data),
    .cmd_vld  (cmd_vld),
    .cmd_chnnl(cmd_chnnl)
`ifdef A2D_SPI_RESP_FRAME_ERR_EN
    ,
    .frm_err  (frm_err)
`endif
  );

  typedef struct {
    int          id;
    logic [31:0] v;
  } word_t;

  int          tests = 0;
  int          fails = 0;
  int          frame_id = 0;
  logic [DW-1:0] model_data [NCH];
  int          model_prev = 0;
  word_t       exp_miso_q[$];
  word_t       got_miso_q[$];
  int          exp_cmd_q[$];
  int          exp_err_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic drive_data();
    for (int k = 0; k < NCH; k++) chnl_data[k*DW +: DW] = model_data[k];
  endtask

  function automatic logic [31:0] cmd_word(input int ch);
    logic [15:0] w;
    logic [2:0]  c;
    w = 16'($urandom);
    c = 3'(ch);
    w[13:11] = c;
    return {16'h0, w};
  endfunction

  // One master frame of n SCLK rises; the last n bits of 'bits' go out MSB first.
  // coinc: one extra rise coincident with SS_n rise. chg_at: zero chnl_data after
  // that many rises. rst_at: pulse rst_n before the fall of that bit index.
  task automatic frame(input logic [31:0] bits, input int n, input bit coinc,
                       input int chg_at, input int rst_at);
    logic [15:0] word;
    logic [31:0] expv;
    logic [31:0] gotv;
    logic [2:0]  ch;
    logic [15:0] last16;
    bit          aborted;
    bit          complete;
    expv    = '0;
    gotv    = '0;
    aborted = 1'b0;
    word    = 16'(model_data[model_prev]);
    frame_id++;
    SS_n = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("miso_after_reset", 32'(MISO), 32'h0);
        aborted = 1'b1;
      end
      SCLK = 1'b0;
      MOSI = bits[n-1-i];
      repeat (H) @(negedge clk);
      gotv = {gotv[30:0], MISO};
      expv = {expv[30:0], (aborted || i >= 16) ? 1'b0 : word[15-i]};
      SCLK = 1'b1;
      repeat (H) @(negedge clk);
      if (i + 1 == chg_at) chnl_data = '0;
    end
    if (aborted) begin
      model_prev = 0;
    end else begin
      last16   = bits[15:0];
      ch       = last16[13:11];
      complete = (n == 16) || (n > 16 && !ERR_EN);
      if (complete) begin
        model_prev = int'(ch);
        exp_cmd_q.push_back(int'(ch));
      end
      if (ERR_EN && n != 16) exp_err_q.push_back(frame_id);
    end
    exp_miso_q.push_back('{frame_id, expv});
    got_miso_q.push_back('{frame_id, gotv});
    if (coinc) begin
      SCLK = 1'b0;
      MOSI = 1'($urandom);
      repeat (H) @(negedge clk);
      SCLK = 1'b1;
      SS_n = 1'b1;
    end else begin
      SS_n = 1'b1;
    end
    repeat (GAP) @(negedge clk);
  endtask

  // Monitor: compares DUT pulses and captured MISO words against the queues.
  initial begin
    word_t g;
    word_t e;
    forever begin
      @(negedge clk);
      if (cmd_vld === 1'b1) begin
        if (exp_cmd_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL cmd_vld_unexpected: got pulse with cmd_chnnl=%0d, expected no pulse", cmd_chnnl);
        end else begin
          check("cmd_chnnl", 32'(cmd_chnnl), 32'(exp_cmd_q.pop_front()));
        end
      end
`ifdef A2D_SPI_RESP_FRAME_ERR_EN
      if (frm_err === 1'b1) begin
        if (exp_err_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL frm_err_unexpected: got pulse, expected none");
        end else begin
          void'(exp_err_q.pop_front());
          tests++;
        end
      end
`endif
      while (got_miso_q.size() > 0 && exp_miso_q.size() > 0) begin
        g = got_miso_q.pop_front();
        e = exp_miso_q.pop_front();
        check($sformatf("miso_frame%0d", e.id), g.v, e.v);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int sel;
    int ch;
    for (int k = 0; k < NCH; k++) model_data[k] = 12'($urandom);
    model_data[0] = 12'h0A5;
    model_data[3] = 12'h7E1;
    drive_data();
    repeat (3) @(negedge clk);
    check("reset_miso", 32'(MISO), 32'h0);
    check("reset_cmd_vld", 32'(cmd_vld), 32'h0);
    check("reset_cmd_chnnl", 32'(cmd_chnnl), 32'h0);
`ifdef A2D_SPI_RESP_FRAME_ERR_EN
    check("reset_frm_err", 32'(frm_err), 32'h0);
`endif
    rst_n = 1'b1;
    repeat (GAP) @(negedge clk);

    // First frames: 0x00A5 then 0x07E1.
    frame(cmd_word(3), 16, 1'b0, -1, -1);
    frame(cmd_word(0), 16, 1'b0, -1, -1);

    // Back-to-back channel sweep, then one more frame returning ch7 = 0x707.
    for (int k = 0; k < NCH; k++) model_data[k] = 12'(12'h100 * k + k);
    drive_data();
    for (int k = 0; k < NCH; k++) frame(cmd_word(k), 16, 1'b0, -1, -1);
    frame(cmd_word(0), 16, 1'b0, -1, -1);

    // Sample snapshot: data drops to zero after bit 4, frame still 0x0FFF.
    for (int k = 0; k < NCH; k++) model_data[k] = 12'hFFF;
    drive_data();
    frame(cmd_word(2), 16, 1'b0, 4, -1);
    for (int k = 0; k < NCH; k++) model_data[k] = 12'h000;

    // Short frame commanding ch5 is discarded; next frame returns ch2.
    for (int k = 0; k < NCH; k++) model_data[k] = 12'($urandom);
    drive_data();
    frame(cmd_word(5) >> 6, 10, 1'b0, -1, -1);
    frame(cmd_word(1), 16, 1'b0, -1, -1);

    // Reset mid-frame with SS_n low; next frame returns ch0.
    frame(cmd_word(6), 16, 1'b0, -1, 7);
    frame(cmd_word(1), 16, 1'b0, -1, -1);

    // SS_n rise coincident with a rise: 15 prior rises discarded, 16 accepted.
    frame(cmd_word(4) >> 1, 15, 1'b1, -1, -1);
    frame(cmd_word(4), 16, 1'b1, -1, -1);
    frame(cmd_word(0), 16, 1'b0, -1, -1);

    // Randomized frames with lengths around the 16-bit boundary.
    for (int f = 0; f < 40; f++) begin
      for (int k = 0; k < NCH; k++) model_data[k] = 12'($urandom);
      drive_data();
      sel = int'($urandom_range(0, 9));
      case (sel)
        0:       n = 0;
        1:       n = 9;
        2:       n = 15;
        3:       n = 17;
        4:       n = 19;
        default: n = 16;
      endcase
      ch = int'($urandom_range(0, 7));
      frame(($urandom << 16) | cmd_word(ch), n, 1'b0, -1, -1);
    end

    repeat (20) @(negedge clk);
    check("cmd_queue_drained", 32'(exp_cmd_q.size()), 32'h0);
    check("err_queue_drained", 32'(exp_err_q.size()), 32'h0);
    check("miso_queue_drained", 32'(exp_miso_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
